operand_fetch_wb: RTL and testbench

OPERAND_FETCH_WB -- requirements
Module: operand_fetch_wb

---
 rtl/operand_fetch_wb.sv | 130 +++++++++++++
 tb/tb_operand_fetch_wb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_wb.sv
// Operand fetch stage with a pending-write scoreboard and a writeback port.
// Optional same-cycle writeback bypass is enabled with OPERAND_FETCH_WB_BYPASS_EN.
module operand_fetch_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [4:0]  iss_rs,
  input  logic [4:0]  iss_rt,
  input  logic [4:0]  iss_rd,
  input  logic        iss_wr,
  output logic [4:0]  rf_addr1,
  output logic [4:0]  rf_addr2,
  input  logic [31:0] rf_data1,
  input  logic [31:0] rf_data2,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [4:0]  op_rd,
  output logic        op_wr,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [5:0]  pend_cnt
);

  logic [31:0] pending_q, pending_d;
  logic [5:0]  pend_cnt_q, pend_cnt_d;
  logic        op_valid_q, op_valid_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [4:0]  op_rd_q, op_rd_d;
  logic        op_wr_q, op_wr_d;

  logic        rs_byp, rt_byp;
  logic        raw_rs, raw_rt, waw;
  logic        accept;
  logic [31:0] src_a, src_b;

  assign rf_addr1 = iss_rs;
  assign rf_addr2 = iss_rt;

  assign rf_we    = wb_valid && (wb_addr != 5'd0);
  assign rf_waddr = wb_addr;
  assign rf_wdata = wb_data;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
  // A writeback landing this edge satisfies a source that is waiting on it.
  assign rs_byp = wb_valid && (wb_addr != 5'd0) && (wb_addr == iss_rs);
  assign rt_byp = wb_valid && (wb_addr != 5'd0) && (wb_addr == iss_rt);
`else
  assign rs_byp = 1'b0;
  assign rt_byp = 1'b0;
`endif

  assign src_a = rs_byp ? wb_data : rf_data1;
  assign src_b = rt_byp ? wb_data : rf_data2;

  assign raw_rs = (iss_rs != 5'd0) && pending_q[iss_rs] && !rs_byp;
  assign raw_rt = (iss_rt != 5'd0) && pending_q[iss_rt] && !rt_byp;
  assign waw    = iss_wr && (iss_rd != 5'd0) && pending_q[iss_rd];

  assign iss_ready = (!op_valid_q || op_ready) && !raw_rs && !raw_rt && !waw;
  assign accept    = iss_valid && iss_ready;

  // Clear first so a same-edge set on the same bit takes priority.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid) begin
      pending_d[wb_addr] = 1'b0;
    end
    if (accept && iss_wr && (iss_rd != 5'd0)) begin
      pending_d[iss_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
    pend_cnt_d = 6'd0;
    for (int i = 0; i < 32; i++) begin
      pend_cnt_d = pend_cnt_d + {5'd0, pending_d[i]};
    end
  end

  always_comb begin
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_rd_d    = op_rd_q;
    op_wr_d    = op_wr_q;
    if (accept) begin
      op_valid_d = 1'b1;
      op_a_d     = src_a;
      op_b_d     = src_b;
      op_rd_d    = iss_rd;
      op_wr_d    = iss_wr;
    end else if (op_ready) begin
      op_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= 32'd0;
      pend_cnt_q <= 6'd0;
      op_valid_q <= 1'b0;
      op_a_q     <= 32'd0;
      op_b_q     <= 32'd0;
      op_rd_q    <= 5'd0;
      op_wr_q    <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_rd_q    <= op_rd_d;
      op_wr_q    <= op_wr_d;
    end
  end

  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_rd    = op_rd_q;
  assign op_wr    = op_wr_q;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_operand_fetch_wb.sv
// Self-checking bench for operand_fetch_wb: directed scenarios plus a randomized run
// against a scoreboard/register-file model (honours OPERAND_FETCH_WB_BYPASS_EN).
module tb_operand_fetch_wb;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid, iss_ready, iss_wr;
  logic [4:0]  iss_rs, iss_rt, iss_rd;
  logic [4:0]  rf_addr1, rf_addr2;
  logic [31:0] rf_data1, rf_data2;
  logic        op_valid, op_ready, op_wr;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic        wb_valid, rf_we;
  logic [4:0]  wb_addr, rf_waddr;
  logic [31:0] wb_data, rf_wdata;
  logic [5:0]  pend_cnt;

  logic [31:0] regs [32];
  int total = 0;
  int bad = 0;

  logic [31:0] m_pend;
  logic        m_ov;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd;
  logic        m_wr;

  always #5 clk = ~clk;

  assign rf_data1 = (rf_addr1 == 5'd0) ? 32'd0 : regs[rf_addr1];
  assign rf_data2 = (rf_addr2 == 5'd0) ? 32'd0 : regs[rf_addr2];

  operand_fetch_wb dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_rd(iss_rd), .iss_wr(iss_wr),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_wr(op_wr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_cnt(pend_cnt)
  );

  // A source is blocked if its register is awaiting a write that has not landed.
  function automatic logic m_blocked(input logic [4:0] r);
    if (r == 5'd0 || !m_pend[r]) return 1'b0;
    if (BYP && wb_valid && wb_addr == r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_ready();
    logic waw;
    waw = iss_wr && (iss_rd != 5'd0) && m_pend[iss_rd];
    return (!m_ov || op_ready) && !m_blocked(iss_rs) && !m_blocked(iss_rt) && !waw;
  endfunction

  function automatic logic [31:0] m_src(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (BYP && wb_valid && wb_addr == r) return wb_data;
    return regs[r];
  endfunction

  task automatic model_reset();
    m_pend = 32'd0; m_ov = 1'b0; m_a = 32'd0; m_b = 32'd0; m_rd = 5'd0; m_wr = 1'b0;
  endtask

  task automatic set_idle();
    iss_valid = 1'b0; iss_rs = 5'd0; iss_rt = 5'd0; iss_rd = 5'd0; iss_wr = 1'b0;
    wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
  endtask

  task automatic drive_issue(input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic wr);
    iss_valid = 1'b1; iss_rs = rs; iss_rt = rt; iss_rd = rd; iss_wr = wr;
  endtask

  // Called mid-cycle with inputs stable: predicts the edge, steps to posedge+1.
  task automatic advance();
    logic acc, rdy, wv, ww;
    logic [31:0] np, na, nb, wd;
    logic [4:0] wa, rd;
    acc = iss_valid && m_ready();
    rdy = op_ready;
    na = m_src(iss_rs); nb = m_src(iss_rt);
    rd = iss_rd; ww = iss_wr;
    wv = wb_valid; wa = wb_addr; wd = wb_data;
    np = m_pend;
    if (wv) np[wa] = 1'b0;
    if (acc && ww && rd != 5'd0) np[rd] = 1'b1;
    @(posedge clk);
    #1;
    if (wv && wa != 5'd0) regs[wa] = wd;
    m_pend = np;
    if (acc) begin
      m_ov = 1'b1; m_a = na; m_b = nb; m_rd = rd; m_wr = ww;
    end else if (rdy) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic test_reset();
    set_idle();
    op_ready = 1'b1;
    model_reset();
    #2;
    total++; if (op_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_op_valid: got %b want 0", op_valid); end
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("[TB] FAIL reset_pend_cnt: got %0d want 0", pend_cnt); end
    total++; if (op_a !== 32'd0 || op_b !== 32'd0) begin bad++; $display("[TB] FAIL reset_operands: got %h/%h want 0/0", op_a, op_b); end
    @(negedge clk);
    rst = 1'b0;
    advance();
  endtask

  task automatic test_basic();
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    @(negedge clk);
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin bad++; $display("[TB] FAIL basic_wb_port: got we=%b a=%0d d=%h want 1/3/11", rf_we, rf_waddr, rf_wdata); end
    advance();
    wb_addr = 5'd4; wb_data = 32'h22;
    @(negedge clk);
    advance();
    set_idle();
    drive_issue(5'd3, 5'd4, 5'd1, 1'b0);
    @(negedge clk);
    total++; if (iss_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_ready: got %b want 1", iss_ready); end
    total++; if (rf_addr1 !== 5'd3 || rf_addr2 !== 5'd4) begin bad++; $display("[TB] FAIL basic_rf_addr: got %0d/%0d want 3/4", rf_addr1, rf_addr2); end
    advance();
    set_idle();
    @(negedge clk);
    total++; if (op_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_op_valid: got %b want 1", op_valid); end
    total++; if (op_a !== 32'h11 || op_b !== 32'h22) begin bad++; $display("[TB] FAIL basic_operands: got %h/%h want 11/22", op_a, op_b); end
    advance();
  endtask

  task automatic test_raw_hazard();
    int k;
    drive_issue(5'd0, 5'd0, 5'd5, 1'b1);
    @(negedge clk);
    total++; if (iss_ready !== 1'b1) begin bad++; $display("[TB] FAIL raw_producer_ready: got %b want 1", iss_ready); end
    advance();
    drive_issue(5'd5, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (iss_ready !== 1'b0) begin bad++; $display("[TB] FAIL raw_stall: got %b want 0", iss_ready); end
      total++; if (pend_cnt !== 6'd1) begin bad++; $display("[TB] FAIL raw_pend_cnt: got %0d want 1", pend_cnt); end
      advance();
    end
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hABCD;
    k = 0;
    while (k < 4) begin
      @(negedge clk);
      if (iss_ready === 1'b1) break;
      advance();
      wb_valid = 1'b0;
      k++;
    end
    total++; if (k !== (BYP ? 0 : 1)) begin bad++; $display("[TB] FAIL raw_release_delay: got %0d cycles want %0d", k, BYP ? 0 : 1); end
    advance();
    set_idle();
    @(negedge clk);
    total++; if (op_valid !== 1'b1 || op_a !== 32'hABCD) begin bad++; $display("[TB] FAIL raw_capture: got v=%b a=%h want 1/abcd", op_valid, op_a); end
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("[TB] FAIL raw_pend_clear: got %0d want 0", pend_cnt); end
    advance();
  endtask

  task automatic test_zero_reg();
    drive_issue(5'd0, 5'd0, 5'd0, 1'b1);
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h55;
    @(negedge clk);
    total++; if (iss_ready !== 1'b1) begin bad++; $display("[TB] FAIL zero_ready: got %b want 1", iss_ready); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("[TB] FAIL zero_rf_we: got %b want 0", rf_we); end
    advance();
    set_idle();
    @(negedge clk);
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("[TB] FAIL zero_pend_cnt: got %0d want 0", pend_cnt); end
    total++; if (op_valid !== 1'b1 || op_a !== 32'd0 || op_wr !== 1'b1 || op_rd !== 5'd0) begin bad++; $display("[TB] FAIL zero_capture: got v=%b a=%h wr=%b rd=%0d want 1/0/1/0", op_valid, op_a, op_wr, op_rd); end
    advance();
  endtask

  task automatic test_backpressure();
    op_ready = 1'b0;
    drive_issue(5'd3, 5'd4, 5'd2, 1'b0);
    @(negedge clk);
    total++; if (iss_ready !== 1'b1) begin bad++; $display("[TB] FAIL hold_first_ready: got %b want 1", iss_ready); end
    advance();
    drive_issue(5'd4, 5'd3, 5'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (iss_ready !== 1'b0) begin bad++; $display("[TB] FAIL hold_ready: got %b want 0", iss_ready); end
      total++; if (op_valid !== 1'b1 || op_a !== 32'h11 || op_b !== 32'h22 || op_rd !== 5'd2) begin bad++; $display("[TB] FAIL hold_stable: got v=%b %h/%h rd=%0d want 1 11/22 rd=2", op_valid, op_a, op_b, op_rd); end
      advance();
    end
    op_ready = 1'b1;
    @(negedge clk);
    total++; if (iss_ready !== 1'b1) begin bad++; $display("[TB] FAIL hold_release_ready: got %b want 1", iss_ready); end
    advance();
    set_idle();
    @(negedge clk);
    total++; if (op_valid !== 1'b1 || op_a !== 32'h22 || op_b !== 32'h11 || op_rd !== 5'd6) begin bad++; $display("[TB] FAIL hold_next_capture: got v=%b %h/%h rd=%0d want 1 22/11 rd=6", op_valid, op_a, op_b, op_rd); end
    advance();
  endtask

  task automatic test_reset_mid();
    op_ready = 1'b1;
    drive_issue(5'd0, 5'd0, 5'd7, 1'b1);
    @(negedge clk);
    advance();
    drive_issue(5'd0, 5'd0, 5'd9, 1'b1);
    @(negedge clk);
    advance();
    set_idle();
    total++; if (pend_cnt !== 6'd2) begin bad++; $display("[TB] FAIL mid_pend_before: got %0d want 2", pend_cnt); end
    #2 rst = 1'b1;
    #1;
    total++; if (op_valid !== 1'b0 || pend_cnt !== 6'd0) begin bad++; $display("[TB] FAIL mid_reset_async: got v=%b cnt=%0d want 0/0", op_valid, pend_cnt); end
    total++; if (op_rd !== 5'd0 || op_wr !== 1'b0 || op_a !== 32'd0) begin bad++; $display("[TB] FAIL mid_reset_regs: got rd=%0d wr=%b a=%h want 0/0/0", op_rd, op_wr, op_a); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    advance();
    drive_issue(5'd7, 5'd9, 5'd0, 1'b0);
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    @(negedge clk);
    total++; if (iss_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_post_ready: got %b want 1", iss_ready); end
    total++; if (rf_we !== 1'b1) begin bad++; $display("[TB] FAIL mid_post_rf_we: got %b want 1", rf_we); end
    advance();
    set_idle();
    @(negedge clk);
    total++; if (op_valid !== 1'b1 || op_a !== m_a || op_b !== m_b) begin bad++; $display("[TB] FAIL mid_post_capture: got v=%b %h/%h want 1 %h/%h", op_valid, op_a, op_b, m_a, m_b); end
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      iss_valid = ($urandom_range(0, 9) < 7);
      iss_rs    = 5'($urandom_range(0, 7));
      iss_rt    = 5'($urandom_range(0, 7));
      iss_rd    = 5'($urandom_range(0, 7));
      iss_wr    = 1'($urandom_range(0, 1));
      op_ready  = ($urandom_range(0, 9) < 7);
      wb_valid  = ($urandom_range(0, 9) < 4);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      @(negedge clk);
      total++; if (iss_ready !== m_ready()) begin bad++; $display("[TB] FAIL rnd_iss_ready @%0d: got %b want %b", n, iss_ready, m_ready()); end
      total++; if (rf_addr1 !== iss_rs || rf_addr2 !== iss_rt) begin bad++; $display("[TB] FAIL rnd_rf_addr @%0d: got %0d/%0d want %0d/%0d", n, rf_addr1, rf_addr2, iss_rs, iss_rt); end
      total++; if (rf_we !== (wb_valid && wb_addr != 5'd0) || rf_waddr !== wb_addr || rf_wdata !== wb_data) begin bad++; $display("[TB] FAIL rnd_wb_port @%0d: got %b/%0d/%h", n, rf_we, rf_waddr, rf_wdata); end
      total++; if (op_valid !== m_ov) begin bad++; $display("[TB] FAIL rnd_op_valid @%0d: got %b want %b", n, op_valid, m_ov); end
      total++; if (op_a !== m_a || op_b !== m_b || op_rd !== m_rd || op_wr !== m_wr) begin bad++; $display("[TB] FAIL rnd_operands @%0d: got %h/%h/%0d/%b want %h/%h/%0d/%b", n, op_a, op_b, op_rd, op_wr, m_a, m_b, m_rd, m_wr); end
      total++; if (pend_cnt !== 6'($countones(m_pend))) begin bad++; $display("[TB] FAIL rnd_pend_cnt @%0d: got %0d want %0d", n, pend_cnt, $countones(m_pend)); end
      advance();
    end
    set_idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    set_idle();
    op_ready = 1'b1;
    test_reset();
    test_basic();
    test_raw_hazard();
    test_zero_reg();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
